// File: rtl/square_gen_pkg.sv
// Shared types and default constants for the programmable square-wave generator.
package square_gen_pkg;

   localparam int unsigned DefWidth  = 28;
   localparam int unsigned DefPeriod = 100;
   localparam int unsigned DefHigh   = 50;

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } state_e;

endpackage

// File: rtl/square_gen_if.sv
// Configuration offer channel: valid/ready handshake carrying period, high time and burst length.
interface square_gen_if
   import square_gen_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth
) ();

   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_period;
   logic [WIDTH-1:0] cfg_high;
   logic [WIDTH-1:0] cfg_cycles;
   logic             cfg_err;

   modport master (
      output cfg_valid,
      output cfg_period,
      output cfg_high,
      output cfg_cycles,
      input  cfg_ready,
      input  cfg_err
   );

   modport slave (
      input  cfg_valid,
      input  cfg_period,
      input  cfg_high,
      input  cfg_cycles,
      output cfg_ready,
      output cfg_err
   );

endinterface

// File: rtl/square_gen_cfg.sv
// Config front end: validates offers, holds one pending config while running, and owns the
// active period/high/burst registers, which only change in IDLE or on a period boundary.
module square_gen_cfg
   import square_gen_pkg::*;
#(
   parameter int unsigned WIDTH      = DefWidth,
   parameter int unsigned DEF_PERIOD = DefPeriod,
   parameter int unsigned DEF_HIGH   = DefHigh
) (
   input  logic             clk,
   input  logic             rst_n,
   square_gen_if.slave      cfg,
   input  logic             idle,
   input  logic             boundary,
   output logic [WIDTH-1:0] act_period,
   output logic [WIDTH-1:0] act_high,
   output logic [WIDTH-1:0] act_cycles
);

   logic             xfer;
   logic             cfg_ok;

   logic             pend_q, pend_d;
   logic [WIDTH-1:0] pend_period_q, pend_period_d;
   logic [WIDTH-1:0] pend_high_q, pend_high_d;
   logic [WIDTH-1:0] pend_cycles_q, pend_cycles_d;

   logic [WIDTH-1:0] act_period_q, act_period_d;
   logic [WIDTH-1:0] act_high_q, act_high_d;
   logic [WIDTH-1:0] act_cycles_q, act_cycles_d;

   logic             err_q, err_d;

   // A slot is free whenever nothing is waiting for a boundary.
   assign cfg.cfg_ready = ~pend_q;
   assign cfg.cfg_err   = err_q;
   assign xfer          = cfg.cfg_valid & ~pend_q;

   assign cfg_ok = (cfg.cfg_period >= WIDTH'(2)) &&
                   (cfg.cfg_high != '0) &&
                   (cfg.cfg_high < cfg.cfg_period);

   always_comb begin
      pend_d        = pend_q;
      pend_period_d = pend_period_q;
      pend_high_d   = pend_high_q;
      pend_cycles_d = pend_cycles_q;
      act_period_d  = act_period_q;
      act_high_d    = act_high_q;
      act_cycles_d  = act_cycles_q;
      err_d         = xfer & ~cfg_ok;

      if (xfer && cfg_ok && idle) begin
         act_period_d = cfg.cfg_period;
         act_high_d   = cfg.cfg_high;
         act_cycles_d = cfg.cfg_cycles;
      end else if (xfer && cfg_ok) begin
         pend_d        = 1'b1;
         pend_period_d = cfg.cfg_period;
         pend_high_d   = cfg.cfg_high;
         pend_cycles_d = cfg.cfg_cycles;
      end else if (pend_q && (idle || boundary)) begin
         // xfer needs an empty slot, so this never collides with a new capture.
         pend_d       = 1'b0;
         act_period_d = pend_period_q;
         act_high_d   = pend_high_q;
         act_cycles_d = pend_cycles_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q        <= 1'b0;
         pend_period_q <= '0;
         pend_high_q   <= '0;
         pend_cycles_q <= '0;
         act_period_q  <= WIDTH'(DEF_PERIOD);
         act_high_q    <= WIDTH'(DEF_HIGH);
         act_cycles_q  <= '0;
         err_q         <= 1'b0;
      end else begin
         pend_q        <= pend_d;
         pend_period_q <= pend_period_d;
         pend_high_q   <= pend_high_d;
         pend_cycles_q <= pend_cycles_d;
         act_period_q  <= act_period_d;
         act_high_q    <= act_high_d;
         act_cycles_q  <= act_cycles_d;
         err_q         <= err_d;
      end
   end

   assign act_period = act_period_q;
   assign act_high   = act_high_q;
   assign act_cycles = act_cycles_q;

endmodule

// File: rtl/square_gen.sv
// Programmable square-wave generator: IDLE/RUN control, phase counter, period count and the
// registered wave output. Config changes land only on period boundaries.
module square_gen
   import square_gen_pkg::*;
#(
   parameter int unsigned WIDTH      = DefWidth,
   parameter int unsigned DEF_PERIOD = DefPeriod,
   parameter int unsigned DEF_HIGH   = DefHigh
) (
   input  logic             clk,
   input  logic             rst_n,
   square_gen_if.slave      cfg,
   input  logic             start,
   input  logic             stop,
   output logic             square,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] period_cnt
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] phase_q, phase_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             square_q, square_d;
   logic             done_q, done_d;
   logic             stop_seen_q, stop_seen_d;

   logic [WIDTH-1:0] act_period;
   logic [WIDTH-1:0] act_high;
   logic [WIDTH-1:0] act_cycles;
   logic             wrap;
   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] phase_inc;

   square_gen_cfg #(
      .WIDTH      (WIDTH),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
   ) u_cfg (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg        (cfg),
      .idle       (state_q == StIdle),
      .boundary   (wrap),
      .act_period (act_period),
      .act_high   (act_high),
      .act_cycles (act_cycles)
   );

   assign wrap      = (state_q == StRun) && (phase_q == act_period - WIDTH'(1));
   assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);
   assign phase_inc = phase_q + WIDTH'(1);

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      cnt_d       = cnt_q;
      square_d    = square_q;
      done_d      = 1'b0;
      stop_seen_d = stop_seen_q;

      unique case (state_q)
         StIdle: begin
            if (start && !stop) begin
               state_d     = StRun;
               phase_d     = '0;
               cnt_d       = '0;
               stop_seen_d = 1'b0;
               // Phase 0 is always high because H >= 1 is enforced on every accepted config.
               square_d    = 1'b1;
            end
         end
         StRun: begin
            if (wrap) begin
               cnt_d   = cnt_inc;
               phase_d = '0;
               if (stop_seen_q || stop ||
                   ((act_cycles != '0) && (cnt_inc >= act_cycles))) begin
                  state_d     = StIdle;
                  done_d      = 1'b1;
                  square_d    = 1'b0;
                  stop_seen_d = 1'b0;
               end else begin
                  square_d = 1'b1;
               end
            end else begin
               phase_d     = phase_inc;
               square_d    = phase_inc < act_high;
               stop_seen_d = stop_seen_q | stop;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         phase_q     <= '0;
         cnt_q       <= '0;
         square_q    <= 1'b0;
         done_q      <= 1'b0;
         stop_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         square_q    <= square_d;
         done_q      <= done_d;
         stop_seen_q <= stop_seen_d;
      end
   end

   assign square     = square_q;
   assign busy       = (state_q == StRun);
   assign done       = done_q;
   assign period_cnt = cnt_q;

endmodule

// File: tb/tb_square_gen.sv
// Directed bench for square_gen: vector tables for config validity and bursts, plus
// hand-written sequences for reconfiguration, stop, start/stop collision and async reset.
module tb_square_gen;
   import square_gen_pkg::*;

   localparam int unsigned W = 28;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         square;
   logic         busy;
   logic         done;
   logic [W-1:0] period_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   square_gen_if #(.WIDTH(W)) cfg_bus ();

   square_gen #(
      .WIDTH      (W),
      .DEF_PERIOD (100),
      .DEF_HIGH   (50)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg        (cfg_bus),
      .start      (start),
      .stop       (stop),
      .square     (square),
      .busy       (busy),
      .done       (done),
      .period_cnt (period_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int unsigned p;
      int unsigned h;
      int unsigned n;
      logic        exp_err;
   } vec_t;

   typedef struct {
      int unsigned p;
      int unsigned h;
      int unsigned n;
      int unsigned exp_cycles;
   } burst_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Walks ncyc cycles comparing square against the ideal P/H wave starting at phase0.
   task automatic check_wave(input int unsigned p, input int unsigned h, input int unsigned phase0,
                             input int unsigned ncyc, input string name);
      int unsigned errs = 0;
      int unsigned ph = phase0;
      for (int unsigned i = 0; i < ncyc; i++) begin
         if (square !== (ph < h)) errs++;
         if (busy !== 1'b1) errs++;
         if (done !== 1'b0) errs++;
         tick();
         ph = (ph + 1 == p) ? 0 : ph + 1;
      end
      check(name, 64'(errs), 64'd0);
   endtask

   task automatic offer(input int unsigned p, input int unsigned h, input int unsigned n);
      cfg_bus.cfg_valid  = 1'b1;
      cfg_bus.cfg_period = W'(p);
      cfg_bus.cfg_high   = W'(h);
      cfg_bus.cfg_cycles = W'(n);
      tick();
      cfg_bus.cfg_valid  = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int unsigned bound, output int unsigned t);
      t = 0;
      while (done !== 1'b1 && t < bound) begin
         tick();
         t++;
      end
   endtask

   vec_t        vecs[8];
   burst_t      bursts[4];
   int unsigned t;
   int unsigned acts;

   initial begin
      cfg_bus.cfg_valid  = 1'b0;
      cfg_bus.cfg_period = '0;
      cfg_bus.cfg_high   = '0;
      cfg_bus.cfg_cycles = '0;

      vecs[0] = '{5, 5, 2, 1'b1};
      vecs[1] = '{1, 0, 2, 1'b1};
      vecs[2] = '{2, 1, 2, 1'b0};
      vecs[3] = '{0, 0, 2, 1'b1};
      vecs[4] = '{3, 2, 2, 1'b0};
      vecs[5] = '{6, 0, 2, 1'b1};
      vecs[6] = '{6, 7, 2, 1'b1};
      vecs[7] = '{2, 2, 2, 1'b1};

      bursts[0] = '{7, 3, 4, 28};
      bursts[1] = '{2, 1, 3, 6};
      bursts[2] = '{5, 4, 2, 10};
      bursts[3] = '{3, 1, 1, 3};

      // Reset values
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst_square", square, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cfg_err", cfg_bus.cfg_err, 0);
      check("rst_cfg_ready", cfg_bus.cfg_ready, 1);
      check("rst_period_cnt", period_cnt, 0);
      #9 rst_n = 1'b1;
      tick();

      // Defaults: 50 high / 50 low, continuous
      pulse_start();
      check_wave(100, 50, 0, 100, "def_wave1");
      check("def_cnt1", period_cnt, 1);
      check_wave(100, 50, 0, 100, "def_wave2");
      check("def_cnt2", period_cnt, 2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done(200, t);
      check("def_stop_lat", t, 99);
      check("def_stop_cnt", period_cnt, 3);
      check("def_stop_busy", busy, 0);
      tick();

      // Validity table in IDLE; the last accepted config is 3/2/2
      foreach (vecs[i]) begin
         offer(vecs[i].p, vecs[i].h, vecs[i].n);
         check($sformatf("vec%0d_err", i), cfg_bus.cfg_err, 64'(vecs[i].exp_err));
         check($sformatf("vec%0d_ready", i), cfg_bus.cfg_ready, 1);
      end
      tick();
      check("vec_err_clear", cfg_bus.cfg_err, 0);
      pulse_start();
      check_wave(3, 2, 0, 6, "vec_keep_wave");
      check("vec_keep_done", done, 1);
      tick();

      // Burst table
      foreach (bursts[i]) begin
         offer(bursts[i].p, bursts[i].h, bursts[i].n);
         pulse_start();
         check_wave(bursts[i].p, bursts[i].h, 0, bursts[i].exp_cycles,
                    $sformatf("burst%0d_wave", i));
         check($sformatf("burst%0d_done", i), done, 1);
         check($sformatf("burst%0d_busy", i), busy, 0);
         check($sformatf("burst%0d_sq", i), square, 0);
         check($sformatf("burst%0d_cnt", i), period_cnt, 64'(bursts[i].n));
         tick();
         check($sformatf("burst%0d_done_pulse", i), done, 0);
      end

      // Reconfig mid-period: 10/5 running, offer 4/1 in phase 3
      offer(10, 5, 0);
      pulse_start();
      check_wave(10, 5, 0, 3, "rc_pre");
      cfg_bus.cfg_valid  = 1'b1;
      cfg_bus.cfg_period = W'(4);
      cfg_bus.cfg_high   = W'(1);
      cfg_bus.cfg_cycles = W'(0);
      check_wave(10, 5, 3, 1, "rc_xfer");
      cfg_bus.cfg_valid = 1'b0;
      check("rc_ready_low", cfg_bus.cfg_ready, 0);
      check_wave(10, 5, 4, 6, "rc_finish_old");
      check("rc_ready_back", cfg_bus.cfg_ready, 1);
      check_wave(4, 1, 0, 8, "rc_new");

      // Invalid offers while running leave the 4/1 wave alone
      offer(5, 5, 0);
      check("inv1_err", cfg_bus.cfg_err, 1);
      tick();
      check("inv1_err_end", cfg_bus.cfg_err, 0);
      offer(1, 0, 0);
      check("inv2_err", cfg_bus.cfg_err, 1);
      tick();
      check("inv2_err_end", cfg_bus.cfg_err, 0);
      check_wave(4, 1, 0, 8, "inv_wave");
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done(20, t);
      check("inv_stop_lat", t, 3);
      tick();

      // Continuous P=8, stop in phase 2: period completes, one done
      offer(8, 3, 0);
      pulse_start();
      check_wave(8, 3, 0, 2, "stop8_pre");
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done(20, t);
      check("stop8_total", t + 3, 8);
      check("stop8_sq", square, 0);
      check("stop8_cnt", period_cnt, 1);
      acts = 0;
      repeat (6) begin
         tick();
         acts += 32'(done);
      end
      check("stop8_single_done", acts, 0);

      // Stop during the final burst period: a single done at the natural end
      offer(4, 2, 2);
      pulse_start();
      check_wave(4, 2, 0, 5, "stoplast_pre");
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_wave(4, 2, 2, 2, "stoplast_post");
      check("stoplast_done", done, 1);
      check("stoplast_cnt", period_cnt, 2);
      acts = 0;
      repeat (6) begin
         tick();
         acts += 32'(done);
      end
      check("stoplast_single_done", acts, 0);

      // start & stop together in IDLE
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      acts = 0;
      repeat (5) begin
         acts += 32'(busy | square | done);
         tick();
      end
      check("startstop_idle", acts, 0);

      // Async reset in the high phase with a pending config
      offer(10, 5, 0);
      pulse_start();
      tick();
      tick();
      offer(4, 1, 0);
      check("rstrun_pending", cfg_bus.cfg_ready, 0);
      check("rstrun_high", square, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rstrun_square", square, 0);
      check("rstrun_busy", busy, 0);
      check("rstrun_done", done, 0);
      check("rstrun_err", cfg_bus.cfg_err, 0);
      check("rstrun_ready", cfg_bus.cfg_ready, 1);
      check("rstrun_cnt", period_cnt, 0);
      #3 rst_n = 1'b1;
      tick();
      pulse_start();
      check_wave(100, 50, 0, 100, "rstrun_default_wave");
      check("rstrun_default_cnt", period_cnt, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done(200, t);
      check("rstrun_stop_lat", t, 99);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/square_gen.md
# square_gen

Programmable square-wave generator: the stimulus end of the frequency-measurement path. It produces a clean square wave with a programmable period and high time, in continuous or burst mode, with glitch-free reconfiguration at period boundaries. It feeds the frequency meter input in self-test and sources test tones for the audio AGC chain.

## Interface
- WIDTH, 28, width of period, high-time and cycle-count fields
- DEF_PERIOD, 100, active period after reset, in clk cycles
- DEF_HIGH, 50, active high time after reset, in clk cycles

- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  configuration slot free
- cfg_period  in  WIDTH  period P in clk cycles
- cfg_high  in  WIDTH  high time H in clk cycles
- cfg_cycles  in  WIDTH  burst length N in periods; 0 = continuous
- cfg_err  out  1  one-cycle pulse: offered config rejected
- start  in  1  begin generation (level sampled per cycle)
- stop  in  1  finish the current period, then halt
- square  out  1  generated wave, registered
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on return to IDLE
- period_cnt  out  WIDTH  completed periods since last start

## Operation
- Config is valid iff P >= 2, 1 <= H <= P-1; else the offer is still accepted (handshake completes) but discarded, with cfg_err pulsed on the following cycle; the active config is unchanged.
- Handshake: transfer on cfg_valid & cfg_ready. In IDLE, a valid config becomes active on the next cycle; cfg_ready stays 1.
- In RUN, a valid config is held pending and cfg_ready = 0 until it is applied. It is applied at the next period boundary; cfg_ready returns to 1 on the cycle after application. Active P/H/N never change mid-period.
- States: IDLE, RUN.
- IDLE -> RUN on start & ~stop: phase counter = 0, period_cnt = 0.
- In RUN, the phase counter counts 0..P-1, then wraps. square = 1 for phase 0..H-1 and 0 for phase H..P-1. At each wrap, period_cnt increments.
- RUN -> IDLE at a wrap when either condition holds:
  - stop was seen (latched) during the period; or
  - N != 0 and period_cnt reaches N.
- On RUN -> IDLE, done pulses once, square = 0, and period_cnt holds its value.
- period_cnt saturates at 2^WIDTH-1 in continuous mode; it does not wrap.
- start in RUN is ignored. start & stop in the same IDLE cycle: stop wins, and the block stays in IDLE.
- stop during the last burst period gives a single done.

## Timing
- Reset values:
  - square = 0, busy = 0, done = 0, cfg_err = 0, cfg_ready = 1, period_cnt = 0
  - active P = DEF_PERIOD, H = DEF_HIGH, N = 0
  - pending config cleared, state IDLE
- square rises on the first cycle after start is sampled (latency 1). busy rises in the same cycle.
- Each period is exactly P clk cycles: H high, P-H low. There is no dropped or extra cycle at a config change.
- Reset asserted mid-RUN: square = 0 immediately (async). Pending config is lost.
- done and the final falling of busy occur in the cycle after the last low phase cycle.

## Structure
- Package square_gen_pkg:
  - state enum {IDLE, RUN}
  - WIDTH default
  - default P/H constants
- Sub-module square_gen_cfg owns:
  - validity check and cfg_err
  - pending register and cfg_ready
  - active P/H/N registers, updated on an apply strobe from the top level
- The top level holds the FSM, the phase counter, period_cnt and the square register.

## Test plan
- Reset defaults, start -> square is 50 high / 50 low, repeating; busy = 1; period_cnt increments every 100 cycles.
- Config P=7, H=3, N=4 in IDLE, then start -> exactly 4 periods of 3 high / 4 low; done pulses 28 cycles after the first high; period_cnt = 4.
- While running P=10, H=5, offer P=4, H=1 mid-period:
  - cfg_ready goes 0 until the boundary;
  - the current period completes as 10 cycles;
  - the next period is 1 high / 3 low.
- Offer P=5, H=5, then P=1, H=0 -> two cfg_err pulses; the wave is unchanged.
- Continuous mode, stop asserted in phase 2 of P=8 -> the period completes, then one done; square = 0 after 8 cycles total. start & stop together in IDLE -> no activity.
- Assert rst_n = 0 during the high phase -> square = 0 immediately, and all outputs are at reset values.
